// File: rtl/midi_parser_pkg.sv
// Shared MIDI constants, parser state encoding and byte/status decode helpers
// used by the midi_parser channel-voice parser.
package midi_parser_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [3:0] POLY_AT      = 4'hA;
  localparam logic [3:0] CC           = 4'hB;
  localparam logic [3:0] PROG         = 4'hC;
  localparam logic [3:0] CHAN_AT      = 4'hD;
  localparam logic [3:0] PITCH        = 4'hE;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA1 = 3'd1,
    ST_DATA2 = 3'd2,
    ST_SKIP1 = 3'd3,
    ST_SKIP2 = 3'd4,
    ST_SYSEX = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_DATA     = 2'd0,
    CLS_STATUS   = 2'd1,
    CLS_REALTIME = 2'd2
  } byte_class_e;

  function automatic byte_class_e byte_class(input logic [7:0] b);
    byte_class_e cls;
    if (b >= REALTIME_MIN) begin
      cls = CLS_REALTIME;
    end else if (b[7]) begin
      cls = CLS_STATUS;
    end else begin
      cls = CLS_DATA;
    end
    return cls;
  endfunction

  // State entered after a channel status byte, by how many data bytes follow.
  function automatic state_e status_target(input logic [3:0] nib);
    state_e st;
    case (nib)
      NOTE_OFF, NOTE_ON:   st = ST_DATA1;
      POLY_AT, CC, PITCH:  st = ST_SKIP2;
      PROG, CHAN_AT:       st = ST_SKIP1;
      default:             st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI channel-voice byte parser: tracks running status, skips realtime/system/
// sysex traffic and emits one registered strobe per Note On/Off on the channel.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  output logic       msg_valid_o,
  output logic       note_on_o,
  output logic [6:0] note_o,
  output logic [6:0] velocity_o,
  output logic [3:0] channel_o,
  output logic       sync_err_o
);

  state_e      state_q;
  logic [7:0]  rs_q;
  logic        rs_valid_q;
  logic [6:0]  data1_q;
  logic        msg_valid_q;
  logic        note_on_q;
  logic [6:0]  note_q;
  logic [6:0]  velocity_q;
  logic [3:0]  channel_q;
  logic        sync_err_q;

  byte_class_e cls_s;
  logic        chan_match_s;

  assign cls_s        = byte_class(rx_byte_i);
  assign chan_match_s = OMNI || (rs_q[3:0] == CHANNEL);

  // Parser FSM, running status and registered message/error outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rs_q        <= 8'h00;
      rs_valid_q  <= 1'b0;
      data1_q     <= 7'h00;
      msg_valid_q <= 1'b0;
      note_on_q   <= 1'b0;
      note_q      <= 7'h00;
      velocity_q  <= 7'h00;
      channel_q   <= 4'h0;
      sync_err_q  <= 1'b0;
    end else begin
      msg_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      if (rx_valid_i) begin
        case (cls_s)
          CLS_REALTIME: begin
            state_q <= state_q;
          end
          CLS_STATUS: begin
            // A status byte cutting off a partially received message is a framing error.
            if ((state_q == ST_DATA2) || (state_q == ST_SKIP1)) begin
              sync_err_q <= 1'b1;
            end else begin
              sync_err_q <= 1'b0;
            end
            if (rx_byte_i < SYSEX_START) begin
              rs_q       <= rx_byte_i;
              rs_valid_q <= 1'b1;
              state_q    <= status_target(rx_byte_i[7:4]);
            end else begin
              rs_valid_q <= 1'b0;
              state_q    <= (rx_byte_i == SYSEX_START) ? ST_SYSEX : ST_IDLE;
            end
          end
          CLS_DATA: begin
            case (state_q)
              ST_IDLE: begin
                if (!rs_valid_q) begin
                  sync_err_q <= 1'b1;
                end else begin
                  case (rs_q[7:4])
                    NOTE_OFF, NOTE_ON: begin
                      data1_q <= rx_byte_i[6:0];
                      state_q <= ST_DATA2;
                    end
                    POLY_AT, CC, PITCH: state_q <= ST_SKIP1;
                    default:            state_q <= ST_IDLE;
                  endcase
                end
              end
              ST_DATA1: begin
                data1_q <= rx_byte_i[6:0];
                state_q <= ST_DATA2;
              end
              ST_DATA2: begin
                state_q <= ST_IDLE;
                // Off-channel messages are consumed silently, leaving outputs held.
                if (chan_match_s) begin
                  msg_valid_q <= 1'b1;
                  note_q      <= data1_q;
                  velocity_q  <= rx_byte_i[6:0];
                  channel_q   <= rs_q[3:0];
                  note_on_q   <= (rs_q[7:4] == NOTE_ON) && (rx_byte_i[6:0] != 7'h00);
                end else begin
                  msg_valid_q <= 1'b0;
                end
              end
              ST_SKIP2: state_q <= ST_SKIP1;
              ST_SKIP1: state_q <= ST_IDLE;
              ST_SYSEX: state_q <= ST_SYSEX;
              default:  state_q <= ST_IDLE;
            endcase
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign msg_valid_o = msg_valid_q;
  assign note_on_o   = note_on_q;
  assign note_o      = note_q;
  assign velocity_o  = velocity_q;
  assign channel_o   = channel_q;
  assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: each driven byte pushes its hand-derived
// expected event (emit / sync error) with the cycle it must appear in.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic       msg_valid, note_on, sync_err;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic       o_msg_valid, o_note_on, o_sync_err;
  logic [6:0] o_note, o_velocity;
  logic [3:0] o_channel;

  typedef struct {
    int         due;
    logic [1:0] kind;  // bit1 = msg_valid, bit0 = sync_err
    logic [6:0] note;
    logic [6:0] vel;
    logic       on;
    logic [3:0] ch;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tid = 0;
  bit   gapped = 1'b0;

  midi_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .msg_valid_o(msg_valid), .note_on_o(note_on), .note_o(note),
    .velocity_o(velocity), .channel_o(channel), .sync_err_o(sync_err)
  );

  midi_parser #(.CHANNEL(4'd3), .OMNI(1'b1)) dut_omni (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .msg_valid_o(o_msg_valid), .note_on_o(o_note_on), .note_o(o_note),
    .velocity_o(o_velocity), .channel_o(o_channel), .sync_err_o(o_sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL t%0d %s got=%0h exp=%0h", tid, tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [1:0] obs;
    if (!rst) begin
      obs = {msg_valid, sync_err};
      if (obs != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(obs), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("kind", 32'(obs), 32'(e.kind));
          chk("latency", 32'(cyc), 32'(e.due));
          if (e.kind[1]) begin
            chk("note", 32'(note), 32'(e.note));
            chk("velocity", 32'(velocity), 32'(e.vel));
            chk("note_on", 32'(note_on), 32'(e.on));
            chk("channel", 32'(channel), 32'(e.ch));
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missing_pulse", 32'(obs), 32'(e.kind));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [1:0] kind, input logic [6:0] n,
                      input logic [6:0] v, input logic on, input logic [3:0] ch);
    exp_t e;
    int   g;
    if (gapped) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (kind != 2'b00) begin
      e.due = cyc + 1; e.kind = kind; e.note = n; e.vel = v; e.on = on; e.ch = ch;
      sb.push_back(e);
    end
  endtask

  task automatic nb(input logic [7:0] b);
    send(b, 2'b00, 7'h00, 7'h00, 1'b0, 4'h0);
  endtask

  task automatic er(input logic [7:0] b);
    send(b, 2'b01, 7'h00, 7'h00, 1'b0, 4'h0);
  endtask

  task automatic em(input logic [7:0] b, input logic [6:0] n, input logic [6:0] v, input logic on);
    send(b, 2'b10, n, v, on, 4'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_test();
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_test(input int id);
    tid = id;
    do_reset(2);
    case (id)
      1: begin nb(8'h90); nb(8'h3C); em(8'h64, 7'h3C, 7'h64, 1'b1); finish_test(); end
      2: begin
        nb(8'h90); nb(8'h3C); em(8'h64, 7'h3C, 7'h64, 1'b1);
        nb(8'h40); em(8'h00, 7'h40, 7'h00, 1'b0); finish_test();
      end
      3: begin
        nb(8'h90); nb(8'hF8); nb(8'h3C); nb(8'hFE); em(8'h64, 7'h3C, 7'h64, 1'b1);
        finish_test();
      end
      4: begin
        nb(8'h90); nb(8'h3C); er(8'h80); nb(8'h3C); em(8'h00, 7'h3C, 7'h00, 1'b0);
        finish_test();
      end
      5: begin
        nb(8'h90); nb(8'h3C); em(8'h64, 7'h3C, 7'h64, 1'b1);
        nb(8'h91); nb(8'h3C); nb(8'h64);
        nb(8'hF0); nb(8'h01); nb(8'h02); nb(8'hF7); er(8'h3C);
        finish_test();
        chk("held_note", 32'(note), 32'h3C);
        chk("held_velocity", 32'(velocity), 32'h64);
        chk("held_note_on", 32'(note_on), 32'd1);
      end
      6: begin
        nb(8'h90);
        do_reset(1);
        er(8'h3C); er(8'h64);
        finish_test();
        chk("rst_note", 32'(note), 32'd0);
        chk("rst_velocity", 32'(velocity), 32'd0);
        chk("rst_note_on", 32'(note_on), 32'd0);
        chk("rst_channel", 32'(channel), 32'd0);
      end
      7: begin
        nb(8'hB0); nb(8'h07); nb(8'h7F); nb(8'h3C); nb(8'h40);
        nb(8'hC2); nb(8'h05); nb(8'h06);
        nb(8'h90); nb(8'h45); em(8'h7F, 7'h45, 7'h7F, 1'b1);
        finish_test();
      end
      8: begin
        nb(8'h9A); nb(8'h3C); nb(8'h64);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("omni_valid", 32'(o_msg_valid), 32'd1);
        chk("omni_channel", 32'(o_channel), 32'hA);
        chk("omni_note", 32'(o_note), 32'h3C);
        chk("omni_velocity", 32'(o_velocity), 32'h64);
        chk("omni_note_on", 32'(o_note_on), 32'd1);
        finish_test();
      end
      default: chk("bad_test_id", 32'(id), 32'd0);
    endcase
  endtask

  initial begin
    do_reset(2);
    @(negedge clk);
    chk("reset_msg_valid", 32'(msg_valid), 32'd0);
    chk("reset_sync_err", 32'(sync_err), 32'd0);
    chk("reset_note", 32'(note), 32'd0);
    chk("reset_velocity", 32'(velocity), 32'd0);
    for (int pass = 0; pass < 2; pass++) begin
      gapped = (pass == 1);
      for (int t = 1; t <= 8; t++) begin
        run_test(t);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
